pipe_buf_stage: RTL and testbench
=================================

# pipe_buf_stage

Parametrised elastic pipeline-stage register with a valid/ready handshake, flush, bubble insertion and a stall-cycle counter. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers: each stage instance carries its payload struct flattened to DATA_W bits. Stage-to-stage backpressure is explicit, so hazard stalls and branch flushes are local to each stage boundary.

## Interface
- DATA_W, 32: payload width in bits; instantiations use $bits of the stage payload struct.
- BUBBLE_VAL, '0: payload driven on out_data when the stage is empty, and loaded at reset and flush (NOP encoding).
- STALL_CNT_W, 16: stall counter width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers a beat.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage accepts a beat this cycle.
- out_valid  out  1  stage holds a beat for downstream.
- out_data  out  DATA_W  head payload, or BUBBLE_VAL when empty.
- out_ready  in  1  downstream consumes the head this cycle.
- flush  in  1  discard all held beats (branch/jump squash).
- clr_stats  in  1  synchronous clear of stall_cnt.
- occupancy  out  2  number of held beats (0..2).
- stall_cnt  out  STALL_CNT_W  saturating count of stalled cycles.

## Operation
- Push = in_valid && in_ready. Pop = out_valid && out_ready. Order is strictly FIFO.
- States: EMPTY, ONE (main entry valid), TWO (main + skid valid; skid build only).
- EMPTY: push → ONE.
- ONE:
  - push && pop → ONE, main ← in_data;
  - push only → TWO, skid ← in_data;
  - pop only → EMPTY, main ← BUBBLE_VAL.
- TWO: no push possible; pop → ONE, main ← skid, skid ← BUBBLE_VAL.
- Flush has priority over everything:
  - while flush = 1, in_ready and out_valid are forced 0 combinationally, so no transfer occurs;
  - next state is EMPTY with both entries at BUBBLE_VAL.
- out_data = main entry; it equals BUBBLE_VAL whenever state is EMPTY.
- Stall counter:
  - increments on each cycle with out_valid && !out_ready && !flush;
  - saturates at 2^STALL_CNT_W−1;
  - clr_stats clears it and has priority over increment;
  - flush does not clear it.
- occupancy: EMPTY = 0, ONE = 1, TWO = 2.

## Timing
- Reset (asynchronous, active-low): state EMPTY, entries = BUBBLE_VAL, out_valid = 0, out_data = BUBBLE_VAL, occupancy = 0, stall_cnt = 0. in_ready = 1 once reset is released (0 while reset is asserted).
- Latency: a beat pushed in cycle N is visible on out_valid/out_data in cycle N+1.
- Throughput is one beat per cycle in steady state when out_ready is held high.
- Reset asserted mid-stream discards all held beats immediately, with no partial update.
- A flush in the same cycle as in_valid = 1 drops that input beat; upstream must not assume it was accepted.
- out_data is stable while out_valid && !out_ready.

## Configuration
- PIPE_BUF_SKID_EN defined:
  - two-entry skid buffer with states EMPTY/ONE/TWO;
  - in_ready is a registered signal (state != TWO, gated only by flush), so there is no combinational out_ready→in_ready path;
  - full throughput is sustained across stage chains.
- PIPE_BUF_SKID_EN undefined:
  - single entry, states EMPTY/ONE; TWO is unreachable and occupancy ≤ 1;
  - in_ready = (state == EMPTY || out_ready) && !flush, a combinational path;
  - lower area, same ordering, flush and counter behaviour.

## Structure
- Shared package pipe_buf_pkg holds:
  - pipe_buf_state_e enum (EMPTY, ONE, TWO);
  - the occupancy encoding constants;
  - the default BUBBLE_VAL constant (NOP encoding 32'h0000_0013 for instruction fields).
- Stage payload structs (if_id, id_ex, ex_mem, mem_wb) remain in their existing package and are cast to DATA_W at instantiation.
- One sub-module, pipe_buf_sat_cnt (parametrised width; inc, clr, saturation), implements stall_cnt.

## Test plan
- Reset, then in_valid = 1 with in_data = 0xA5 and out_ready = 1 → cycle after push: out_valid = 1, out_data = 0xA5, occupancy = 1. Stage empty at reset → out_data = BUBBLE_VAL, stall_cnt = 0.
- Skid: stream 0x1, 0x2, 0x3 with out_ready = 0 → occupancy reaches 2 and in_ready = 0. Release out_ready → pops 0x1, 0x2, then 0x3 in order with no loss or duplication.
- Flush in TWO with in_valid = 1, in_data = 0x9 → in_ready = out_valid = 0 in the flush cycle; next cycle occupancy = 0, out_data = BUBBLE_VAL, and 0x9 is never emitted.
- Stall counter: STALL_CNT_W = 3, out_valid held with out_ready = 0 for 10 cycles → stall_cnt saturates at 7. clr_stats for one cycle → 0, then resumes counting.
- Assert reset low mid-stream with occupancy = 2 → outputs take reset values immediately, without waiting for a clock edge.
- Non-skid build: out_ready = 1 with the stage in ONE → in_ready = 1 in the same cycle, and back-to-back pushes sustain 1 beat/cycle with occupancy never exceeding 1.

Source files
------------

// File: rtl/pipe_buf_pkg.sv
// Shared types and constants for the elastic pipeline-stage buffer.
// Holds the stage state encoding, occupancy codes and the default NOP bubble.
package pipe_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_buf_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // addi x0, x0, 0 : the canonical NOP for instruction-carrying stages
  localparam logic [31:0] PIPE_BUF_NOP = 32'h0000_0013;

  function automatic logic [1:0] occ_of(input pipe_buf_state_e s);
    case (s)
      EMPTY:   return OCC_EMPTY;
      ONE:     return OCC_ONE;
      TWO:     return OCC_TWO;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_buf_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_buf_sat_cnt
  import pipe_buf_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_buf_stage.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and stall counter.
// Define PIPE_BUF_SKID_EN for the two-entry skid build (registered in_ready).
//
// state | meaning
// EMPTY | no beat held, out_data = BUBBLE_VAL
// ONE   | main entry holds the head beat
// TWO   | main + skid entries both valid (skid build only)
module pipe_buf_stage
  import pipe_buf_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL  = '0,
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic                   clr_stats,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_buf_state_e   state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic              push, pop;

`ifdef PIPE_BUF_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_nxt;
  // depends only on the state register, so no out_ready -> in_ready path
  assign in_ready = reset && (state != TWO) && !flush;
`else
  assign in_ready = reset && ((state == EMPTY) || out_ready) && !flush;
`endif

  assign out_valid = (state != EMPTY) && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = main_q;
  assign occupancy = occ_of(state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= BUBBLE_VAL;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
    end
  end

`ifdef PIPE_BUF_SKID_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) skid_q <= BUBBLE_VAL;
    else        skid_q <= skid_nxt;
  end
`endif

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
`ifdef PIPE_BUF_SKID_EN
    skid_nxt  = skid_q;
`endif
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = BUBBLE_VAL;
`ifdef PIPE_BUF_SKID_EN
      skid_nxt  = BUBBLE_VAL;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_nxt = in_data;
          end else if (pop) begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE_VAL;
          end
`ifdef PIPE_BUF_SKID_EN
          else if (push) begin
            state_nxt = TWO;
            skid_nxt  = in_data;
          end
`endif
        end
`ifdef PIPE_BUF_SKID_EN
        TWO: begin
          if (pop) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
            skid_nxt  = BUBBLE_VAL;
          end
        end
`endif
        default: begin
          state_nxt = EMPTY;
          main_nxt  = BUBBLE_VAL;
        end
      endcase
    end
  end

  pipe_buf_sat_cnt #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .clr   (clr_stats),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Scoreboard bench for pipe_buf_stage; expectations follow PIPE_BUF_SKID_EN if defined.
module tb_pipe_buf_stage;

  localparam logic [31:0] BUB = 32'h0000_0013;
`ifdef PIPE_BUF_SKID_EN
  localparam int EXP_FULL = 2;
`else
  localparam int EXP_FULL = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        clr_stats = 1'b0;
  logic [1:0]  occupancy;
  logic [2:0]  stall_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  pipe_buf_stage #(
    .DATA_W      (32),
    .BUBBLE_VAL  (BUB),
    .STALL_CNT_W (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .clr_stats (clr_stats),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted beats, compare every popped head in order.
  always @(negedge clk) begin
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got %h expected none", out_data);
        end else begin
          check("pop_data", out_data, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data, BUB);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // single beat with downstream ready
    cyc(); in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
    @(negedge clk);
    check("basic_in_ready", 32'(in_ready), 32'd1);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_out_data",  out_data, 32'hA5);
    check("basic_occupancy", 32'(occupancy), 32'd1);
    cyc();
    @(negedge clk);
    check("basic_empty_occ",  32'(occupancy), 32'd0);
    check("basic_empty_data", out_data, BUB);

`ifdef PIPE_BUF_SKID_EN
    cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    cyc(); in_data = 32'h2;
    @(negedge clk);
    check("skid_rdy_one", 32'(in_ready), 32'd1);
    cyc(); in_data = 32'h3;
    @(negedge clk);
    check("skid_occ_two",   32'(occupancy), 32'd2);
    check("skid_rdy_two",   32'(in_ready), 32'd0);
    check("skid_head_data", out_data, 32'h1);
    cyc(); out_ready = 1'b1;
    @(negedge clk);
    check("skid_rdy_registered", 32'(in_ready), 32'd0);
    cyc();
    cyc(); in_valid = 1'b0;
    cyc();
    @(negedge clk);
    check("skid_drained_occ", 32'(occupancy), 32'd0);

    cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h4;
    cyc(); in_data = 32'h5;
    cyc(); in_data = 32'h9; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready",  32'(in_ready), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_pre_occ",   32'(occupancy), 32'd2);
`else
    cyc(); out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h10 + 32'(i);
      @(negedge clk);
      check("b2b_in_ready",  32'(in_ready), 32'd1);
      check("b2b_occupancy", 32'(occupancy), (i == 0) ? 32'd0 : 32'd1);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_tail_occ", 32'(occupancy), 32'd1);
    cyc();
    @(negedge clk);
    check("b2b_empty_occ", 32'(occupancy), 32'd0);

    cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h20;
    cyc(); in_data = 32'h21;
    @(negedge clk);
    check("ns_stall_in_ready", 32'(in_ready), 32'd0);
    check("ns_stall_occ",      32'(occupancy), 32'd1);
    cyc(); in_data = 32'h9; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready",  32'(in_ready), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
`endif
    cyc(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_post_occ",   32'(occupancy), 32'd0);
    check("flush_post_data",  out_data, BUB);
    check("flush_post_valid", 32'(out_valid), 32'd0);
    cyc(); out_ready = 1'b1;
    repeat (3) cyc();

    // stall counter saturation and clear
    out_ready = 1'b0; clr_stats = 1'b1;
    cyc(); clr_stats = 1'b0;
    @(negedge clk);
    check("stall_clr_init", 32'(stall_cnt), 32'd0);
    cyc(); in_valid = 1'b1; in_data = 32'h30;
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    check("stall_start", 32'(stall_cnt), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      @(negedge clk);
      check("stall_cnt", 32'(stall_cnt), (i > 7) ? 32'd7 : 32'(i));
      check("stall_hold_data", out_data, 32'h30);
    end
    cyc(); clr_stats = 1'b1;
    cyc(); clr_stats = 1'b0;
    @(negedge clk);
    check("stall_cleared", 32'(stall_cnt), 32'd0);
    cyc();
    @(negedge clk);
    check("stall_resume", 32'(stall_cnt), 32'd1);
    cyc(); out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    cyc();
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    // asynchronous reset while holding beats
    cyc(); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h40;
    cyc(); in_data = 32'h41;
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    check("midrst_pre_occ", 32'(occupancy), 32'(EXP_FULL));
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  out_data, BUB);
    check("midrst_occupancy", 32'(occupancy), 32'd0);
    check("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("midrst_in_ready",  32'(in_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1; out_ready = 1'b1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
